// File: rtl/ma_dcache_if.sv
// Pipeline-side and backing-memory-side signals of ma_dcache.
// The cache takes the slave modport; MA stage and memory drive the master side.
interface ma_dcache_if #(
  parameter int unsigned WIDTH = 32
);
  logic [1:0]       ma;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             miss;
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  ma, addr, wdata, mem_ack, mem_rdata,
    output rdata, miss, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ma, addr, wdata, mem_ack, mem_rdata,
    input  rdata, miss, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ma_dcache.sv
// Direct-mapped write-through data cache with one-word lines between MA stage and memory.
// Optional feature: define DCACHE_WALLOC_EN to allocate a line on a store miss.
module ma_dcache #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned IDX_BITS = 4
) (
  input logic        clk,
  input logic        rst,
  ma_dcache_if.slave bus
);
  localparam int unsigned Lines = 2 ** IDX_BITS;
  localparam int unsigned TagW  = WIDTH - IDX_BITS - 2;

  typedef enum logic [1:0] {StIdle, StFill, StWrite} state_e;

  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic [Lines-1:0] valid_q;
  logic [TagW-1:0]  tag_q  [Lines];
  logic [WIDTH-1:0] data_q [Lines];

  logic                is_load, is_store;
  logic [IDX_BITS-1:0] req_idx, line_idx;
  logic [TagW-1:0]     req_tag, line_tag;
  logic                req_hit, line_hit, ack;
  logic [WIDTH-1:0]    word_addr;
  logic                line_we;
  logic [WIDTH-1:0]    line_wdata;
  logic [WIDTH-1:0]    rdata;
  logic                miss;
  logic                unused_addr_lsb;

  assign is_load   = (bus.ma == 2'b10);
  assign is_store  = (bus.ma == 2'b11);
  assign req_idx   = bus.addr[IDX_BITS+1:2];
  assign req_tag   = bus.addr[WIDTH-1:IDX_BITS+2];
  assign req_hit   = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign word_addr = {bus.addr[WIDTH-1:2], 2'b00};

  // Line updates use the registered request address, which stays put until the ack.
  assign line_idx  = mem_addr_q[IDX_BITS+1:2];
  assign line_tag  = mem_addr_q[WIDTH-1:IDX_BITS+2];
  assign line_hit  = valid_q[line_idx] && (tag_q[line_idx] == line_tag);
  assign ack       = bus.mem_ack && mem_req_q;

  assign unused_addr_lsb = ^bus.addr[1:0];

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    line_we     = 1'b0;
    line_wdata  = bus.mem_rdata;
    rdata       = '0;
    miss        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (is_load) begin
          if (req_hit) begin
            rdata = data_q[req_idx];
          end else begin
            miss       = 1'b1;
            state_d    = StFill;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = word_addr;
          end
        end else if (is_store && !done_q) begin
          miss        = 1'b1;
          state_d     = StWrite;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = word_addr;
          mem_wdata_d = bus.wdata;
        end
      end

      StFill: begin
        miss = 1'b1;
        if (ack) begin
          line_we   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = StIdle;
        end
      end

      StWrite: begin
        miss       = 1'b1;
        line_wdata = mem_wdata_q;
        if (ack) begin
`ifdef DCACHE_WALLOC_EN
          line_we = 1'b1;
`else
          line_we = line_hit;
`endif
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          state_d   = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      done_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (line_we) begin
      valid_q[line_idx] <= 1'b1;
    end
  end

  // Reset wins over a same-cycle ack, so tag/data are gated as well.
  always_ff @(posedge clk) begin
    if (!rst && line_we) begin
      tag_q[line_idx]  <= line_tag;
      data_q[line_idx] <= line_wdata;
    end
  end

  assign bus.rdata     = rdata;
  assign bus.miss      = miss;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
